// File: rtl/can_msg_buf_ram_pkg.sv
// can_ram_pkg: shared state encoding and preload pattern for the CAN message RAM.
package can_ram_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  function automatic logic [31:0] initWord(input logic [31:0] ptr, input int len);
    return (ptr < 32'(len)) ? ptr : '0;
  endfunction
endpackage

// File: rtl/can_sdp_ram_core.sv
// can_sdp_ram_core: byte-enabled simple dual-port array, registered read, no reset.
module can_sdp_ram_core #(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DW / 8; i++)
      if (we && wbe[i]) mem[waddr][8*i+:8] <= wdata[8*i+:8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/can_msg_buf_ram.sv
// can_msg_buf_ram: SDP message RAM with byte enables, write-first bypass and clear/preload sweep.
module can_msg_buf_ram
  import can_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH = 1 << ADDR_WIDTH,
  parameter int INIT_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clrReq,
  output logic                    busy,
  input  logic                    wrEn,
  input  logic [ADDR_WIDTH-1:0]   wrAddr,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic [DATA_WIDTH/8-1:0] wrBe,
  input  logic                    rdEn,
  input  logic [ADDR_WIDTH-1:0]   rdAddr,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic                    rdValid
);
  state_t state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic wr_ok, rd_ok, rd_in, oor_q;
  logic [DATA_WIDTH/8-1:0] byp_be;
  logic [DATA_WIDTH-1:0] byp_d, core_q, merged;
  assign wr_ok = !busy && wrEn && 32'(wrAddr) < RAM_DEPTH;
  assign rd_ok = !busy && rdEn;
  assign rd_in = 32'(rdAddr) < RAM_DEPTH;
  can_sdp_ram_core #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(RAM_DEPTH)) u_core (
    .clk(clk),
    .we(busy || wr_ok),
    .waddr(busy ? ptr : wrAddr),
    .wdata(busy ? DATA_WIDTH'(initWord(32'(ptr), INIT_LEN)) : wrData),
    .wbe(busy ? '1 : wrBe),
    .re(rd_ok && rd_in),
    .raddr(rdAddr),
    .rdata(core_q)
  );
  // core returns pre-write contents on a collision; lanes written that cycle come from the bypass copy
  always_comb begin
    merged = core_q;
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      merged[8*i+:8] = byp_be[i] ? byp_d[8*i+:8] : core_q[8*i+:8];
  end
  assign rdData = oor_q ? '0 : merged;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= ST_CLEAR;
      busy    <= 1'b1;
      ptr     <= '0;
      rdValid <= 1'b0;
      oor_q   <= 1'b1;
      byp_be  <= '0;
      byp_d   <= '0;
    end else begin
      rdValid <= rd_ok;
      if (rd_ok) begin
        oor_q  <= !rd_in;
        byp_be <= (wr_ok && wrAddr == rdAddr) ? wrBe : '0;
        byp_d  <= wrData;
      end
      if (state == ST_CLEAR) begin
        ptr <= ptr + 1'b1;
        if (ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else if (clrReq) begin
        state <= ST_CLEAR;
        busy  <= 1'b1;
        ptr   <= '0;
      end
    end
endmodule
